// File: rtl/i2c_target_if.sv
// I2C target bus pins plus register-write notification bundle.
// slave: target side; master: bus/SoC side that drives pins and observes writes.
interface i2c_target_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       busy;
  logic       wr_stb;
  logic [3:0] wr_idx;
  logic [7:0] wr_data;

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_oe,
    output busy,
    output wr_stb,
    output wr_idx,
    output wr_data
  );

  modport master (
    output scl_i,
    output sda_i,
    input  sda_oe,
    input  busy,
    input  wr_stb,
    input  wr_idx,
    input  wr_data
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target at fixed 7-bit ADDR with a 16x8 register file and auto-increment pointer.
// Ports: clk, rst (async active-low), bus (scl_i/sda_i in; sda_oe, busy, wr_stb/idx/data out).
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input logic        clk,
  input logic        rst,
  i2c_target_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT_STOP
  } state_t;

  // Synchronisers plus edge register; reset high = idle bus.
  logic scl_m, scl_s, scl_d;
  logic sda_m, sda_s, sda_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_d <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_m <= bus.scl_i;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= bus.sda_i;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

  // Control state
  state_t     state, state_d;
  logic       oe_q, oe_d;
  logic       ack_on, ack_d;
  logic [3:0] bit_cnt, cnt_d;
  logic       busy_q, busy_d;

  // Datapath
  logic [7:0] regs [16];
  logic [3:0] ptr;
  logic [6:0] shreg;
  logic [7:0] rd_sh;
  logic       wr_stb_q;
  logic [3:0] wr_idx_q;
  logic [7:0] wr_data_q;

  // Datapath strobes from the FSM
  logic shift_en, ptr_ld, ptr_inc, wr_en, rd_ld;

  logic [7:0] byte_in;
  logic       last_bit;
  logic [3:0] ptr_nx;
  logic [3:0] rd_idx;

  assign byte_in  = {shreg, sda_s};
  assign last_bit = (bit_cnt == 4'd7);
  assign ptr_nx   = ptr + 4'd1;
  assign rd_idx   = ptr_inc ? ptr_nx : ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      oe_q    <= 1'b0;
      ack_on  <= 1'b0;
      bit_cnt <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      oe_q    <= oe_d;
      ack_on  <= ack_d;
      bit_cnt <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state;
    oe_d     = oe_q;
    ack_d    = ack_on;
    cnt_d    = bit_cnt;
    busy_d   = busy_q;
    shift_en = 1'b0;
    ptr_ld   = 1'b0;
    ptr_inc  = 1'b0;
    wr_en    = 1'b0;
    rd_ld    = 1'b0;
    if (start_ev) begin
      state_d = S_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
    end else if (stop_ev) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_WAIT_STOP: begin
          oe_d = 1'b0;
        end
        S_ADDR: begin
          if (scl_rise) begin
            shift_en = 1'b1;
            cnt_d    = bit_cnt + 4'd1;
            if (last_bit) begin
              if (byte_in[7:1] == ADDR) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          // First fall asserts ACK, second fall ends it.
          // shreg[0] holds the R/W bit here.
          if (scl_fall) begin
            if (!ack_on) begin
              oe_d  = 1'b1;
              ack_d = 1'b1;
            end else begin
              ack_d = 1'b0;
              cnt_d = 4'd0;
              if (shreg[0]) begin
                state_d = S_RDATA;
                rd_ld   = 1'b1;
                oe_d    = ~regs[ptr][7];
              end else begin
                state_d = S_PTR;
                oe_d    = 1'b0;
              end
            end
          end
        end
        S_PTR: begin
          if (scl_rise) begin
            shift_en = 1'b1;
            cnt_d    = bit_cnt + 4'd1;
            if (last_bit) begin
              ptr_ld  = 1'b1;
              state_d = S_PTR_ACK;
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              oe_d  = 1'b1;
              ack_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              ack_d   = 1'b0;
              cnt_d   = 4'd0;
              state_d = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (scl_rise) begin
            shift_en = 1'b1;
            cnt_d    = bit_cnt + 4'd1;
            if (last_bit) begin
              wr_en   = 1'b1;
              state_d = S_WDATA_ACK;
            end
          end
        end
        S_RDATA: begin
          // bit_cnt counts SCL rises; the bit for the
          // next low phase is rd_sh[7 - bit_cnt].
          if (scl_rise) begin
            cnt_d = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              oe_d    = 1'b0;
              state_d = S_RDATA_ACK;
            end else begin
              oe_d = ~rd_sh[~bit_cnt[2:0]];
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_inc = 1'b1;
              rd_ld   = 1'b1;
              cnt_d   = 4'd0;
              state_d = S_RDATA;
            end else begin
              oe_d    = 1'b0;
              state_d = S_WAIT_STOP;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      ptr       <= 4'd0;
      shreg     <= 7'd0;
      rd_sh     <= 8'h00;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= 4'd0;
      wr_data_q <= 8'h00;
    end else begin
      wr_stb_q <= wr_en;
      if (shift_en) shreg <= byte_in[6:0];
      if (ptr_ld) begin
        ptr <= byte_in[3:0];
      end else if (wr_en || ptr_inc) begin
        ptr <= ptr_nx;
      end
      if (wr_en) begin
        regs[ptr] <= byte_in;
        wr_idx_q  <= ptr;
        wr_data_q <= byte_in;
      end
      if (rd_ld) rd_sh <= regs[rd_idx];
    end
  end

  assign bus.sda_oe  = oe_q;
  assign bus.busy    = busy_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_idx  = wr_idx_q;
  assign bus.wr_data = wr_data_q;

endmodule
